// File: rtl/rf_wr_arb_pkg.sv
// Shared constants for the register-file write arbiter.
// Requester indices, select width and default data width.
package rf_wr_arb_pkg;
  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;
  localparam int SELW = 3;
  localparam int DATAW = 16;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant core.
// Owns the last-grant pointer; grants are combinational.
module rr_arb2
  import rf_wr_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       halt,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic lastgrant;
  logic en;
  logic both;

  assign en = !rst && !halt;
  assign both = req[REQ_ALU] && req[REQ_MEM];

  always_comb begin
    grant = '0;
    unique case (1'b1)
      !en: grant = '0;
      en && both: begin
        // lastgrant holds the index of the previous winner
        grant[REQ_ALU] = lastgrant;
        grant[REQ_MEM] = !lastgrant;
      end
      en && req[REQ_ALU] && !req[REQ_MEM]:
        grant[REQ_ALU] = 1'b1;
      en && req[REQ_MEM] && !req[REQ_ALU]:
        grant[REQ_MEM] = 1'b1;
      default: grant = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lastgrant <= 1'b1;
    end else if (|grant) begin
      lastgrant <= grant[REQ_MEM];
    end
  end

endmodule

// File: rtl/rf_wr_arb.sv
// Shares the register-file write port between ALU and load writeback,
// stages the winner for one cycle and forwards staged data to readers.
module rf_wr_arb
  import rf_wr_arb_pkg::*;
#(
  parameter int width = DATAW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [SELW-1:0]   sel0,
  input  logic [SELW-1:0]   sel1,
  input  logic [width-1:0]  data0,
  input  logic [width-1:0]  data1,
  output logic              ready0,
  output logic              ready1,
  input  logic              halt,
  output logic              write,
  output logic [SELW-1:0]   writeregsel,
  output logic [width-1:0]  writedata,
  input  logic [SELW-1:0]   rd1sel,
  input  logic [SELW-1:0]   rd2sel,
  input  logic [width-1:0]  rfRead1data,
  input  logic [width-1:0]  rfRead2data,
  output logic [width-1:0]  read1data,
  output logic [width-1:0]  read2data,
  output logic              err
);

  logic [1:0] grant;
  logic       conflict;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .halt  (halt),
    .req   ({req1, req0}),
    .grant (grant)
  );

  assign ready0 = grant[REQ_ALU];
  assign ready1 = grant[REQ_MEM];

  // Same destination in one cycle: flagged, but both writes still go out
  assign conflict = req0 && req1 && (sel0 == sel1) && !halt;

  always_ff @(posedge clk) begin
    if (rst) begin
      write       <= 1'b0;
      writeregsel <= '0;
      writedata   <= '0;
      err         <= 1'b0;
    end else begin
      write <= |grant;
      err   <= conflict;
      if (grant[REQ_ALU]) begin
        writeregsel <= sel0;
        writedata   <= data0;
      end else if (grant[REQ_MEM]) begin
        writeregsel <= sel1;
        writedata   <= data1;
      end
    end
  end

  assign read1data = (write && rd1sel == writeregsel)
                   ? writedata : rfRead1data;
  assign read2data = (write && rd2sel == writeregsel)
                   ? writedata : rfRead2data;

endmodule

// File: tb/tb_rf_wr_arb.sv
// Directed bench for rf_wr_arb with a write scoreboard
// and a behavioural register file behind the write port.
module tb_rf_wr_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic        halt = 1'b0;
  logic [2:0]  sel0 = '0;
  logic [2:0]  sel1 = '0;
  logic [15:0] data0 = '0;
  logic [15:0] data1 = '0;
  logic [2:0]  rd1sel = '0;
  logic [2:0]  rd2sel = '0;
  logic        ready0, ready1, write, err;
  logic [2:0]  writeregsel;
  logic [15:0] writedata;
  logic [15:0] rfRead1data, rfRead2data;
  logic [15:0] read1data, read2data;
  logic [15:0] mem [8];

  logic [18:0] expq [$];
  int nchk = 0;
  int nerr = 0;

  rf_wr_arb #(.width(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0        (req0),
    .req1        (req1),
    .sel0        (sel0),
    .sel1        (sel1),
    .data0       (data0),
    .data1       (data1),
    .ready0      (ready0),
    .ready1      (ready1),
    .halt        (halt),
    .write       (write),
    .writeregsel (writeregsel),
    .writedata   (writedata),
    .rd1sel      (rd1sel),
    .rd2sel      (rd2sel),
    .rfRead1data (rfRead1data),
    .rfRead2data (rfRead2data),
    .read1data   (read1data),
    .read2data   (read2data),
    .err         (err)
  );

  always #5 clk = ~clk;

  // register file: commits on the edge ending the write cycle
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
      mem[4] <= 16'h0042;
    end else if (write === 1'b1) begin
      mem[writeregsel] <= writedata;
    end
  end

  assign rfRead1data = mem[rd1sel];
  assign rfRead2data = mem[rd2sel];

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every staged write must match the oldest expected grant
  always @(posedge clk) begin
    logic [18:0] e;
    #2;
    if (write === 1'b1) begin
      if (expq.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL unexpected_write: got r%0d=%h expected none at %0t",
                 writeregsel, writedata, $time);
      end else begin
        e = expq.pop_front();
        chk("wr_sel", 16'(writeregsel), 16'(e[18:16]));
        chk("wr_data", writedata, e[15:0]);
      end
    end else if (expq.size() != 0) begin
      e = expq.pop_front();
      nchk++;
      nerr++;
      $display("FAIL missing_write: got write=%b expected r%0d=%h at %0t",
               write, e[18:16], e[15:0], $time);
    end
  end

  task automatic drive(input logic r, input logic h,
                       input logic q0, input logic [2:0] s0,
                       input logic [15:0] d0,
                       input logic q1, input logic [2:0] s1,
                       input logic [15:0] d1,
                       input logic e0, input logic e1);
    @(posedge clk);
    #1;
    rst = r;
    halt = h;
    req0 = q0;
    sel0 = s0;
    data0 = d0;
    req1 = q1;
    sel1 = s1;
    data1 = d1;
    #3;
    chk("ready0", 16'(ready0), 16'(e0));
    chk("ready1", 16'(ready1), 16'(e1));
    if (e0) expq.push_back({s0, d0});
    if (e1) expq.push_back({s1, d1});
  endtask

  task automatic idle();
    drive(0, 0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 0, 0);
  endtask

  logic [15:0] c0 [6];
  logic [15:0] c1 [6];

  initial begin
    c0 = '{16'h1000, 16'h1001, 16'h1001, 16'h1002, 16'h1002, 16'h1003};
    c1 = '{16'h2000, 16'h2000, 16'h2001, 16'h2001, 16'h2002, 16'h2002};

    drive(1, 0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 0, 0);
    drive(1, 0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 0, 0);
    idle();
    chk("rst_write", 16'(write), 16'h0);
    chk("rst_sel", 16'(writeregsel), 16'h0);
    chk("rst_data", writedata, 16'h0);
    chk("rst_err", 16'(err), 16'h0);

    // single ALU write, forwarded then read from rf
    drive(0, 0, 1, 3'd3, 16'h1234, 0, 3'd0, 16'h0, 1, 0);
    rd1sel = 3'd3;
    idle();
    chk("fwd_r3", read1data, 16'h1234);
    idle();
    chk("rf_r3", read1data, 16'h1234);
    chk("r3_write_low", 16'(write), 16'h0);

    // forwarding vs raw rf data
    drive(0, 0, 1, 3'd2, 16'hBEEF, 0, 3'd0, 16'h0, 1, 0);
    rd1sel = 3'd2;
    rd2sel = 3'd4;
    idle();
    chk("fwd_r2", read1data, 16'hBEEF);
    chk("raw_r4", read2data, 16'h0042);

    // halt blocks a pending load writeback
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 3'd0, 16'h0, 1, 3'd6, 16'h6666, 0, 0);
      chk("halt_write", 16'(write), 16'h0);
    end
    drive(0, 0, 0, 3'd0, 16'h0, 1, 3'd6, 16'h6666, 0, 1);

    // continuous contention alternates 0,1,0,1,0,1
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 1, 3'd1, c0[i], 1, 3'd2, c1[i], (i % 2) == 0, (i % 2) == 1);
      chk("bb_write", 16'(write), 16'h1);
    end
    idle();
    chk("bb_write_last", 16'(write), 16'h1);

    // same-destination conflict
    rd1sel = 3'd5;
    drive(0, 0, 1, 3'd5, 16'hAAAA, 1, 3'd5, 16'h5555, 1, 0);
    drive(0, 0, 0, 3'd0, 16'h0, 1, 3'd5, 16'h5555, 0, 1);
    chk("err_set", 16'(err), 16'h1);
    chk("fwd_r5_first", read1data, 16'hAAAA);
    idle();
    chk("err_clear", 16'(err), 16'h0);
    chk("fwd_r5_second", read1data, 16'h5555);
    idle();
    chk("rf_r5", read1data, 16'h5555);

    // reset while a write is staged
    drive(0, 0, 1, 3'd7, 16'h7777, 0, 3'd0, 16'h0, 1, 0);
    drive(1, 0, 1, 3'd4, 16'h4444, 1, 3'd4, 16'h9999, 0, 0);
    chk("rst_cycle_write", 16'(write), 16'h1);
    drive(0, 0, 1, 3'd4, 16'h4444, 1, 3'd4, 16'h9999, 1, 0);
    chk("midrst_write", 16'(write), 16'h0);
    chk("midrst_sel", 16'(writeregsel), 16'h0);
    chk("midrst_data", writedata, 16'h0);
    chk("midrst_err", 16'(err), 16'h0);
    drive(0, 0, 0, 3'd0, 16'h0, 1, 3'd4, 16'h9999, 0, 1);
    chk("err_after_rst", 16'(err), 16'h1);
    idle();
    idle();
    idle();
    chk("queue_empty", 16'(expq.size()), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
